change_dispenser: RTL and testbench

- Downstream of vending_machine: takes the change amount in cents produced at the end of a vend or cancel and drives coin-hopper solenoids one coin at a time.
- Uses a greedy largest-coin-first algorithm. Each coin is a timed pulse followed by a mandatory gap.
- Reports busy/done and a coin tally to the display path.

---
 rtl/change_dispenser.sv | 145 ++++++++++++++
 tb/tb_change_dispenser.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin-hopper driver: pays out a cents amount one timed coin pulse at a time.
// Optional: define FIFTY_COIN_EN to add a 50c hopper (coin_fifty) to the greedy set.
module change_dispenser #(
    parameter int AMOUNT_W     = 10,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic                abort,
    output logic                coin_dollar,
`ifdef FIFTY_COIN_EN
    output logic                coin_fifty,
`endif
    output logic                coin_quarter,
    output logic                coin_dime,
    output logic                coin_nickel,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [AMOUNT_W-1:0] remaining,
    output logic [5:0]          coins_out
);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
    typedef enum logic [2:0] {C_NONE, C_NICKEL, C_DIME, C_QUARTER, C_FIFTY, C_DOLLAR} coin_t;

    state_t              state;
    logic [7:0]          timer;
    coin_t               pick;
    logic [AMOUNT_W-1:0] pickVal;

    function automatic logic [5:0] satInc(input logic [5:0] c);
        return (c == 6'd63) ? c : c + 6'd1;
    endfunction

    function automatic logic isRagged(input logic [AMOUNT_W-1:0] a);
        return (a % AMOUNT_W'(5)) != '0;
    endfunction

    // Largest coin that still fits in what is left to pay.
    always_comb begin
        pick    = C_NONE;
        pickVal = '0;
        if (remaining >= AMOUNT_W'(100)) begin
            pick    = C_DOLLAR;
            pickVal = AMOUNT_W'(100);
        end
`ifdef FIFTY_COIN_EN
        else if (remaining >= AMOUNT_W'(50)) begin
            pick    = C_FIFTY;
            pickVal = AMOUNT_W'(50);
        end
`endif
        else if (remaining >= AMOUNT_W'(25)) begin
            pick    = C_QUARTER;
            pickVal = AMOUNT_W'(25);
        end else if (remaining >= AMOUNT_W'(10)) begin
            pick    = C_DIME;
            pickVal = AMOUNT_W'(10);
        end else if (remaining >= AMOUNT_W'(5)) begin
            pick    = C_NICKEL;
            pickVal = AMOUNT_W'(5);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            coin_dollar  <= 1'b0;
`ifdef FIFTY_COIN_EN
            coin_fifty   <= 1'b0;
`endif
            coin_quarter <= 1'b0;
            coin_dime    <= 1'b0;
            coin_nickel  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            remaining    <= '0;
            coins_out    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= amount;
                        coins_out <= '0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (abort || pick == C_NONE) begin
                        done  <= 1'b1;
                        // Coins are all multiples of 5, so the residue mirrors the latched amount.
                        err   <= isRagged(remaining);
                        state <= DONE;
                    end else begin
                        remaining    <= remaining - pickVal;
                        coins_out    <= satInc(coins_out);
                        coin_dollar  <= (pick == C_DOLLAR);
`ifdef FIFTY_COIN_EN
                        coin_fifty   <= (pick == C_FIFTY);
`endif
                        coin_quarter <= (pick == C_QUARTER);
                        coin_dime    <= (pick == C_DIME);
                        coin_nickel  <= (pick == C_NICKEL);
                        timer        <= 8'(PULSE_CYCLES - 1);
                        state        <= PULSE;
                    end
                end
                PULSE: begin
                    if (timer == 8'd0) begin
                        coin_dollar  <= 1'b0;
`ifdef FIFTY_COIN_EN
                        coin_fifty   <= 1'b0;
`endif
                        coin_quarter <= 1'b0;
                        coin_dime    <= 1'b0;
                        coin_nickel  <= 1'b0;
                        timer        <= 8'(GAP_CYCLES - 1);
                        state        <= GAP;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                GAP: begin
                    if (timer == 8'd0) state <= SELECT;
                    else               timer <= timer - 8'd1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin sequences, timing, abort, residue and reset.
module tb_change_dispenser;

    localparam logic [4:0] FIF = 5'b10000;
    localparam logic [4:0] DOL = 5'b01000;
    localparam logic [4:0] QTR = 5'b00100;
    localparam logic [4:0] DIM = 5'b00010;
    localparam logic [4:0] NIK = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] amount = '0;
    logic       abort = 1'b0;
    logic       coinDollar, coinQuarter, coinDime, coinNickel;
    logic       busy, done, err;
    logic [9:0] remaining;
    logic [5:0] coinsOut;
    logic       coinFiftyBit;

    int total = 0;
    int bad = 0;
    logic [4:0] tr [0:255];
    logic       busyTr [0:255];
    int doneAt;
    logic [9:0] remAtDone;
    logic [5:0] coinsAtDone;
    logic       errAtDone;

`ifdef FIFTY_COIN_EN
    logic coinFifty;
    assign coinFiftyBit = coinFifty;
`else
    assign coinFiftyBit = 1'b0;
`endif

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .amount       (amount),
        .abort        (abort),
        .coin_dollar  (coinDollar),
`ifdef FIFTY_COIN_EN
        .coin_fifty   (coinFifty),
`endif
        .coin_quarter (coinQuarter),
        .coin_dime    (coinDime),
        .coin_nickel  (coinNickel),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .remaining    (remaining),
        .coins_out    (coinsOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Caller sits just after a negedge with the DUT idle; k counts cycles after the start cycle.
    task automatic runTrace(input logic [9:0] amt, input int abortAt, input int extraStartAt);
        amount = amt;
        start  = 1'b1;
        doneAt = -1;
        for (int k = 1; k <= 200 && doneAt < 0; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            tr[k]     = {coinFiftyBit, coinDollar, coinQuarter, coinDime, coinNickel};
            busyTr[k] = busy;
            if (k == abortAt) abort = 1'b1;
            if (k == extraStartAt) begin
                start  = 1'b1;
                amount = 10'd5;
            end
            if (k == extraStartAt + 1) start = 1'b0;
            if (done) begin
                doneAt      = k;
                remAtDone   = remaining;
                coinsAtDone = coinsOut;
                errAtDone   = err;
            end
        end
    endtask

    task automatic checkTrace(input string tag, input logic [39:0] seq, input int n);
        int mism;
        logic [4:0] e;
        mism = 0;
        for (int k = 1; k <= doneAt; k++) begin
            e = '0;
            for (int i = 0; i < n; i++)
                if (k >= 2 + 7 * i && k <= 5 + 7 * i) e = seq[i*5 +: 5];
            if (tr[k] !== e || busyTr[k] !== 1'b1) mism++;
        end
        check(tag, mism, 0);
    endtask

    task automatic checkIdleAfter(input string tag);
        @(negedge clk);
        check({tag, "_doneLow"}, done, 0);
        check({tag, "_busyLow"}, busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coins", {coinFiftyBit, coinDollar, coinQuarter, coinDime, coinNickel}, 0);
        check("rst_remaining", remaining, 0);
        check("rst_coinsOut", coinsOut, 0);
        reset = 1'b0;
        @(negedge clk);

        // 40c: quarter, dime, nickel
        runTrace(10'd40, -1, -1);
        check("a40_doneAt", doneAt, 23);
        checkTrace("a40_trace", {25'b0, NIK, DIM, QTR}, 3);
        check("a40_coinsOut", coinsAtDone, 3);
        check("a40_remaining", remAtDone, 0);
        check("a40_err", errAtDone, 0);
        checkIdleAfter("a40");

        // 0c: straight to done
        runTrace(10'd0, -1, -1);
        check("a0_doneAt", doneAt, 2);
        checkTrace("a0_trace", 40'b0, 0);
        check("a0_coinsOut", coinsAtDone, 0);
        check("a0_err", errAtDone, 0);
        checkIdleAfter("a0");

        // 142c: dollar, quarter, dime, nickel with 2c residue
        runTrace(10'd142, -1, -1);
        check("a142_doneAt", doneAt, 30);
        checkTrace("a142_trace", {20'b0, NIK, DIM, QTR, DOL}, 4);
        check("a142_remaining", remAtDone, 2);
        check("a142_err", errAtDone, 1);
        check("a142_coinsOut", coinsAtDone, 4);
        // start coinciding with done must be ignored
        amount = 10'd100;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("startAtDone_busy", busy, 0);
        check("startAtDone_err", err, 0);
        repeat (3) @(negedge clk);
        check("hold_busy", busy, 0);
        check("hold_remaining", remaining, 2);
        check("hold_coinsOut", coinsOut, 4);

        // 135c with abort raised mid dollar pulse, plus a stray start while busy
        runTrace(10'd135, 3, 4);
        check("abort_doneAt", doneAt, 9);
        checkTrace("abort_trace", {35'b0, DOL}, 1);
        check("abort_remaining", remAtDone, 35);
        check("abort_coinsOut", coinsAtDone, 1);
        check("abort_err", errAtDone, 0);
        abort = 1'b0;
        checkIdleAfter("abort");
        check("abort_holdRemaining", remaining, 35);

        // 75c: fifty+quarter with the 50c hopper, else three quarters
        runTrace(10'd75, -1, -1);
`ifdef FIFTY_COIN_EN
        check("a75_doneAt", doneAt, 16);
        checkTrace("a75_trace", {30'b0, QTR, FIF}, 2);
        check("a75_coinsOut", coinsAtDone, 2);
`else
        check("a75_doneAt", doneAt, 23);
        checkTrace("a75_trace", {25'b0, QTR, QTR, QTR}, 3);
        check("a75_coinsOut", coinsAtDone, 3);
`endif
        check("a75_remaining", remAtDone, 0);
        checkIdleAfter("a75");

        // Asynchronous reset in the middle of a quarter pulse
        amount = 10'd25;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midRst_quarterHigh", coinQuarter, 1);
        #1 reset = 1'b1;
        #1;
        check("midRst_quarterDrop", coinQuarter, 0);
        check("midRst_busy", busy, 0);
        check("midRst_remaining", remaining, 0);
        check("midRst_coinsOut", coinsOut, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("postRst_busy", busy, 0);
        runTrace(10'd5, -1, -1);
        check("postRst_doneAt", doneAt, 9);
        checkTrace("postRst_trace", {35'b0, NIK}, 1);
        check("postRst_coinsOut", coinsAtDone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
